alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU. Same 3-bit opcode set, generalised to WIDTH bits.
- Output is registered and comes with status flags (zero, carry, overflow).
- Shifts are iterative, one bit position per cycle, so one small shifter serves any WIDTH.
- Sits between an operand producer and a result consumer, using valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width; must be >= 2.
- SHW, $clog2(WIDTH), derived localparam; shift-amount width; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operands/opcode valid.
- in_ready_o  output  1  block can accept a new operation.
- op_i  input  3  opcode: 000 ADD, 001 SUB, 010 SLL, 011 LSR, 100 AND, 101 OR, 110 XOR, 111 EQL.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B; for SLL/LSR only b_i[SHW-1:0] (the shift amount) is used.
- out_valid_o  output  1  result/flags valid.
- out_ready_i  input  1  consumer accepts result.
- alu_o  output  WIDTH  result.
- zero_o  output  1  alu_o == 0.
- carry_o  output  1  carry/borrow/last shifted-out bit.
- ovf_o  output  1  signed overflow (ADD/SUB only).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. Reset overrides all other inputs.
- After a clock edge with reset high:
  - state = IDLE, out_valid_o = 0.
  - alu_o = 0, zero_o = 0, carry_o = 0, ovf_o = 0.
  - internal shift counter = 0.
- FSM states:
  - IDLE: in_ready_o = 1, out_valid_o = 0.
  - SHIFT: in_ready_o = 0, out_valid_o = 0.
  - HOLD: in_ready_o = 0, out_valid_o = 1.
- in_ready_o is decoded purely from state (no combinational path from out_ready_i).
- Accept: in_valid_i & in_ready_o at an edge. Operands and opcode are captured; inputs are ignored outside IDLE.
- Non-shift op, or shift with amount 0:
  - Result and flags are registered at the accept edge; IDLE -> HOLD.
  - Latency: accept at edge N, so out_valid_o is high after edge N.
- Shift with amount k > 0:
  - At the accept edge, A is loaded into the working register and the counter is set to k; IDLE -> SHIFT.
  - Each SHIFT cycle shifts by one bit (SLL left, LSR logical right, zero fill), captures the shifted-out bit into carry_o, and decrements the counter.
  - The cycle the counter reaches 0 moves SHIFT -> HOLD.
  - out_valid_o rises k edges after the accept edge, i.e. k+1 cycles after accept.
- HOLD:
  - alu_o and the flags stay stable.
  - out_ready_i = 1 at an edge moves HOLD -> IDLE and drops out_valid_o.
  - Throughput is at most one op per 2 cycles; there is no accept while in HOLD.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: carry_o = carry out of the MSB. ovf_o = signed overflow (operands share a sign, result sign differs).
  - SUB: carry_o = borrow (a_i < b_i, unsigned). ovf_o = signed overflow (operand signs differ, result sign differs from A).
  - AND / OR / XOR: bitwise. carry_o = 0, ovf_o = 0.
  - EQL: alu_o = all ones when a_i == b_i, else all zeros. carry_o = 0, ovf_o = 0.
  - Shifts: ovf_o = 0. carry_o = last bit shifted out; 0 when the amount is 0. Shift amount range is 0..WIDTH-1.
- zero_o = (alu_o == 0) for every op and is updated together with alu_o.
- Reset in SHIFT or HOLD aborts the op: no result is presented and the pending result is lost.
- Reset asserted in the same cycle as in_valid_i: the op is not accepted.
- No X on any output after the first reset edge.

Test Plan (WIDTH=8):
- ADD a=0xF0, b=0x20 accepted at edge N -> out_valid_o high after N, alu_o=0x10, carry_o=1, zero_o=0, ovf_o=0; out_ready_i=1 -> IDLE, in_ready_o=1 next cycle.
- SUB a=0x80, b=0x01 -> alu_o=0x7F, ovf_o=1, carry_o=0. Then SUB a=0x05, b=0x05 -> alu_o=0x00, zero_o=1, carry_o=0.
- SLL a=0x81, b=0x03 -> in_ready_o low for 4 cycles, out_valid_o after edge N+3, alu_o=0x08, carry_o=0. LSR a=0x81, b=0x01 -> alu_o=0x40, carry_o=1, out_valid_o after N+1. SLL with b=0x00 -> alu_o=0x81, carry_o=0, latency 1.
- Backpressure: ADD result in HOLD with out_ready_i=0 for 5 cycles while in_valid_i=1 with new operands -> alu_o/flags unchanged, in_ready_o=0, new op not accepted; accepted only after the HOLD->IDLE edge.
- Reset mid-op: SLL a=0x01, b=0x07, assert reset 3 cycles after accept -> out_valid_o=0, alu_o=0x00, flags 0, never any result. Next EQL a=0x5A, b=0x5A -> alu_o=0xFF, latency 1.
- Random regression: 1000 random ops with random in_valid_i/out_ready_i stalls, checked against a reference model -> every accepted op yields exactly one result, in order, with correct flags.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: producer side (in_*) and consumer side (out_*).
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] alu_o;
  logic             zero_o;
  logic             carry_o;
  logic             ovf_o;

  modport slave (
    input  in_valid_i, op_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_o, zero_o, carry_o, ovf_o
  );

  modport master (
    output in_valid_i, op_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_o, zero_o, carry_o, ovf_o
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags; shifts step one bit per cycle
// through the result register so a single 1-bit shifter serves any WIDTH.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_LSR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, cy_q, cy_d, ov_q, ov_d, left_q, left_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   amt;
  logic             acc, is_shift, sa, sb;

  assign acc      = bus.in_valid_i & (state_q == IDLE);
  assign amt      = bus.b_i[SHW-1:0];
  assign is_shift = (bus.op_i == OP_SLL) || (bus.op_i == OP_LSR);
  assign sum      = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign dif      = {1'b0, bus.a_i} - {1'b0, bus.b_i};
  assign sa       = bus.a_i[WIDTH-1];
  assign sb       = bus.b_i[WIDTH-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = (is_shift && amt != '0) ? SHIFT : HOLD;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = HOLD;
      HOLD:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Result register doubles as the shift working register while in SHIFT.
  always_comb begin
    res_d  = res_q;
    cy_d   = cy_q;
    ov_d   = ov_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (acc) begin
      cy_d   = 1'b0;
      ov_d   = 1'b0;
      cnt_d  = is_shift ? amt : '0;
      left_d = (bus.op_i == OP_SLL);
      case (bus.op_i)
        OP_ADD: begin
          res_d = sum[WIDTH-1:0];
          cy_d  = sum[WIDTH];
          ov_d  = (sa == sb) && (sum[WIDTH-1] != sa);
        end
        OP_SUB: begin
          res_d = dif[WIDTH-1:0];
          cy_d  = dif[WIDTH];
          ov_d  = (sa != sb) && (dif[WIDTH-1] != sa);
        end
        OP_SLL, OP_LSR: res_d = bus.a_i;
        OP_AND:  res_d = bus.a_i & bus.b_i;
        OP_OR:   res_d = bus.a_i | bus.b_i;
        OP_XOR:  res_d = bus.a_i ^ bus.b_i;
        default: res_d = (bus.a_i == bus.b_i) ? '1 : '0;
      endcase
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q - SHW'(1);
      if (left_q) {cy_d, res_d} = {res_q, 1'b0};
      else        {res_d, cy_d} = {1'b0, res_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      cy_q   <= 1'b0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= (res_d == '0);
      cy_q   <= cy_d;
      ov_q   <= ov_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == HOLD);
  assign bus.alu_o       = res_q;
  assign bus.zero_o      = zero_q;
  assign bus.carry_o     = cy_q;
  assign bus.ovf_o       = ov_q;
endmodule
